hack_cpu_mc: RTL

//  Parametrised multi-cycle Hack-ISA CPU core with request/acknowledge handshakes on separate instruction and data memory ports.

---
 rtl/hack_cpu_mc_pkg.sv | 27 ++
 rtl/hack_cpu_mc_if.sv | 26 ++
 rtl/hack_cpu_mc_alu.sv | 24 ++
 rtl/hack_cpu_mc.sv | 124 ++++++++++++
 4 files changed

// File: rtl/hack_cpu_mc_pkg.sv
// Shared types for the multi-cycle Hack core: FSM states, instruction field positions, jump decode.
package hack_cpu_mc_pkg;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_MEM_RD,
    S_EXEC,
    S_MEM_WR,
    S_HALT
  } state_t;

  localparam int ABIT    = 12;
  localparam int COMP_HI = 11;
  localparam int COMP_LO = 6;
  localparam int DEST_A  = 5;
  localparam int DEST_D  = 4;
  localparam int DEST_M  = 3;
  localparam int JLT     = 2;
  localparam int JEQ     = 1;
  localparam int JGT     = 0;

  function automatic logic jump_taken(input logic [2:0] j, input logic zr, input logic ng);
    return (ng & j[2]) | (zr & j[1]) | (~ng & ~zr & j[0]);
  endfunction

endpackage

// File: rtl/hack_cpu_mc_if.sv
// Instruction and data memory req/ack bus; req and its qualifiers stay stable until the ack cycle.
interface hack_cpu_mc_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = DATA_W - 1
);
  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_ack;
  logic [DATA_W-1:0] inst;
  logic              data_req;
  logic              data_we;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic              data_ack;
  logic [DATA_W-1:0] data_rdata;

  modport master (
    output inst_req, inst_addr, data_req, data_we, data_addr, data_wdata,
    input  inst_ack, inst, data_ack, data_rdata
  );

  modport slave (
    input  inst_req, inst_addr, data_req, data_we, data_addr, data_wdata,
    output inst_ack, inst, data_ack, data_rdata
  );
endinterface

// File: rtl/hack_cpu_mc_alu.sv
// Combinational Hack ALU: zero/negate each operand, add or AND, optionally negate the result.
module hack_alu #(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] y,
  input  logic [5:0]        fn,
  output logic [DATA_W-1:0] out,
  output logic              zr,
  output logic              ng
);
  logic [DATA_W-1:0] xz, xn, yz, yn, f;

  always_comb begin
    xz  = fn[5] ? '0 : x;
    xn  = fn[4] ? ~xz : xz;
    yz  = fn[3] ? '0 : y;
    yn  = fn[2] ? ~yz : yz;
    f   = fn[1] ? (xn + yn) : (xn & yn);
    out = fn[0] ? ~f : f;
    zr  = (out == '0);
    ng  = out[DATA_W-1];
  end
endmodule

// File: rtl/hack_cpu_mc.sv
// Multi-cycle Hack CPU: FETCH/DECODE/[MEM_RD]/EXEC/[MEM_WR]; A-inst 2 cycles, C-inst 3 (+1 per M access) plus wait states.
// Stalls indefinitely in any memory state until the matching ack; a taken jump to itself parks the core in HALT.
module hack_cpu_mc
  import hack_cpu_mc_pkg::*;
#(
  parameter int              DATA_W      = 16,
  parameter int              ADDR_W      = DATA_W - 1,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter bit              HALT_DETECT = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  hack_cpu_mc_if.master      bus,
  output logic               retire,
  output logic               halted
);
  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_inc, target;
  logic [DATA_W-1:0] a_q, d_q, ir, m_q, res_q;
  logic              zr_q, ng_q;
  logic [DATA_W-1:0] alu_y, alu_out, res;
  logic              alu_zr, alu_ng, zr, ng;
  logic              is_c, commit, jump, self_loop;

  hack_alu #(.DATA_W(DATA_W)) u_alu (
    .x   (d_q),
    .y   (alu_y),
    .fn  (ir[COMP_HI:COMP_LO]),
    .out (alu_out),
    .zr  (alu_zr),
    .ng  (alu_ng)
  );

  // In MEM_WR the result was latched in EXEC; otherwise commit straight from the ALU.
  assign alu_y     = ir[ABIT] ? m_q : a_q;
  assign res       = (state == S_MEM_WR) ? res_q : alu_out;
  assign zr        = (state == S_MEM_WR) ? zr_q  : alu_zr;
  assign ng        = (state == S_MEM_WR) ? ng_q  : alu_ng;
  assign is_c      = ir[DATA_W-1];
  assign commit    = ((state == S_EXEC) && !ir[DEST_M]) || ((state == S_MEM_WR) && bus.data_ack);
  assign jump      = jump_taken(ir[JLT:JGT], zr, ng);
  assign target    = a_q[ADDR_W-1:0];
  assign pc_inc    = pc + ADDR_W'(1);
  assign self_loop = HALT_DETECT && jump && (target == pc);

  assign bus.inst_addr  = pc;
  assign bus.data_addr  = a_q[ADDR_W-1:0];
  assign bus.data_wdata = res_q;

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:  if (bus.inst_ack) state_nxt = S_DECODE;
      S_DECODE: begin
        if (!is_c)         state_nxt = S_FETCH;
        else if (ir[ABIT]) state_nxt = S_MEM_RD;
        else               state_nxt = S_EXEC;
      end
      S_MEM_RD: if (bus.data_ack) state_nxt = S_EXEC;
      S_EXEC: begin
        if (ir[DEST_M])     state_nxt = S_MEM_WR;
        else if (self_loop) state_nxt = S_HALT;
        else                state_nxt = S_FETCH;
      end
      S_MEM_WR: if (bus.data_ack) state_nxt = self_loop ? S_HALT : S_FETCH;
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_FETCH;
    endcase
  end

  always_comb begin
    bus.inst_req = 1'b0;
    bus.data_req = 1'b0;
    bus.data_we  = 1'b0;
    retire       = 1'b0;
    halted       = 1'b0;
    if (!reset) begin
      bus.inst_req = (state == S_FETCH);
      bus.data_req = (state == S_MEM_RD) || (state == S_MEM_WR);
      bus.data_we  = (state == S_MEM_WR);
      halted       = (state == S_HALT);
      retire       = commit || ((state == S_DECODE) && !is_c);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc    <= RESET_PC;
      a_q   <= '0;
      d_q   <= '0;
      ir    <= '0;
      m_q   <= '0;
      res_q <= '0;
      zr_q  <= 1'b0;
      ng_q  <= 1'b0;
    end else begin
      case (state)
        S_FETCH:  if (bus.inst_ack) ir <= bus.inst;
        S_DECODE: if (!is_c) begin
          a_q <= {1'b0, ir[DATA_W-2:0]};
          pc  <= pc_inc;
        end
        S_MEM_RD: if (bus.data_ack) m_q <= bus.data_rdata;
        S_EXEC: begin
          res_q <= alu_out;
          zr_q  <= alu_zr;
          ng_q  <= alu_ng;
        end
        default: ;
      endcase
      // The jump target and M address above use A before this commit overwrites it.
      if (commit) begin
        if (ir[DEST_A]) a_q <= res;
        if (ir[DEST_D]) d_q <= res;
        if (!self_loop) pc <= jump ? target : pc_inc;
      end
    end
  end
endmodule
